// File: rtl/ring_pkg.sv
// ============================================================================
// Module      : ring_pkg
// Description : Shared types, defaults and the one-hot successor helper for
//               the ring counter checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_pkg;

    localparam int unsigned N_DEF    = 4;
    localparam int unsigned IDXW_DEF = 2;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Rotate the low n bits of v toward the MSB by one; bit n-1 wraps to bit 0.
    // Valid for 2 <= n <= 31.
    function automatic logic [31:0] rot_succ(input logic [31:0] v, input int unsigned n);
        logic [31:0] mask;
        mask     = (32'd1 << n) - 32'd1;
        rot_succ = ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ring_chk_onehot_dec.sv
// ============================================================================
// Module      : onehot_dec
// Description : Combinational one-hot legality test and binary position decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_dec
    import ring_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned IDXW = IDXW_DEF
) (
    input  logic [N-1:0]    ring,
    output logic            is_onehot,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        is_onehot = ($countones(ring) == 1);
        idx       = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (ring[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ring_chk.sv
// ============================================================================
// Module      : ring_chk
// Description : In-system monitor for a one-hot ring counter: decodes the
//               position, tracks lock and counts successor violations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_chk
    import ring_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned IDXW     = IDXW_DEF,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned ERRW     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic [N-1:0]    ring,
    output logic [IDXW-1:0] idx,
    output logic            idx_valid,
    output logic            locked,
    output logic            err,
    output logic [ERRW-1:0] err_cnt
);

    localparam int unsigned CNTW = $clog2(LOCK_CNT + 1);
    localparam logic [CNTW-1:0] c_LAST_GOOD = CNTW'(LOCK_CNT - 1);
    localparam logic [ERRW-1:0] c_ERR_MAX   = '1;

    logic [N-1:0]    r_ring_q;
    logic            r_adv_q;
    logic [N-1:0]    r_prev_ring;
    logic            r_prev_adv;
    logic            r_prev_ok;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNTW-1:0] r_good_cnt;
    logic [CNTW-1:0] w_good_cnt_nxt;
    logic            w_onehot;
    logic [IDXW-1:0] w_idx;
    logic [N-1:0]    w_expect;
    logic            w_good;
    logic            w_err;

    onehot_dec #(
        .N    (N),
        .IDXW (IDXW)
    ) u_dec (
        .ring      (r_ring_q),
        .is_onehot (w_onehot),
        .idx       (w_idx)
    );

    // The counter moves on the same edge that samples adv, so the successor
    // of a sample is predicted from the adv captured alongside it.
    assign w_expect = r_prev_adv ? N'(rot_succ(32'(r_prev_ring), N)) : r_prev_ring;
    assign w_good   = w_onehot && r_prev_ok && (r_ring_q == w_expect);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_err          = 1'b0;
        case (r_state)
            HUNT: begin
                if (!w_good) begin
                    w_good_cnt_nxt = '0;
                end else if (r_good_cnt == c_LAST_GOOD) begin
                    w_state_nxt    = LOCKED;
                    w_good_cnt_nxt = '0;
                end else begin
                    w_good_cnt_nxt = r_good_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (!w_good) begin
                    w_err          = 1'b1;
                    w_state_nxt    = HUNT;
                    w_good_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = HUNT;
                w_good_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ring_q    <= '0;
            r_adv_q     <= 1'b0;
            r_prev_ring <= '0;
            r_prev_adv  <= 1'b0;
            r_prev_ok   <= 1'b0;
            idx         <= '0;
            idx_valid   <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            r_ring_q    <= ring;
            r_adv_q     <= adv;
            r_prev_ring <= r_ring_q;
            r_prev_adv  <= r_adv_q;
            r_prev_ok   <= w_onehot;
            if (w_onehot) begin
                idx <= w_idx;
            end
            idx_valid <= w_onehot;
            err       <= w_err;
            if (w_err && (err_cnt != c_ERR_MAX)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign locked = (r_state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_ring_chk.sv
// ============================================================================
// Module      : tb_ring_chk
// Description : Directed self-checking bench for ring_chk (ERRW=8 and ERRW=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_chk;

    logic       clk;
    logic       rst;
    logic       adv;
    logic [3:0] ring;

    logic [1:0] idx,   idx3;
    logic       idx_valid, idx_valid3;
    logic       locked, locked3;
    logic       err, err3;
    logic [7:0] err_cnt;
    logic [2:0] err_cnt3;

    int checks;
    int errors;

    ring_chk #(.N(4), .IDXW(2), .LOCK_CNT(2), .ERRW(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .ring      (ring),
        .idx       (idx),
        .idx_valid (idx_valid),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    ring_chk #(.N(4), .IDXW(2), .LOCK_CNT(2), .ERRW(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .ring      (ring),
        .idx       (idx3),
        .idx_valid (idx_valid3),
        .locked    (locked3),
        .err       (err3),
        .err_cnt   (err_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; adv = 1'b0; ring = 4'b0001;
        tick(); tick();
        checks++;
        if (idx !== 2'd0 || idx_valid !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset: idx=%0d vld=%b lck=%b err=%b cnt=%0d, required 0 0 0 0 0",
                     idx, idx_valid, locked, err, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_hold_lock();
        logic exp_lck [5];
        exp_lck = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        ring = 4'b0001; adv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k >= 1) begin
                checks++;
                if (idx !== 2'd0 || idx_valid !== 1'b1 || err !== 1'b0 || err_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL hold_idx[%0d]: idx=%0d vld=%b err=%b cnt=%0d, required 0 1 0 0",
                             k, idx, idx_valid, err, err_cnt);
                end
            end
            checks++;
            if (locked !== exp_lck[k]) begin
                errors++;
                $display("FAIL hold_lock[%0d]: locked=%b, required %b", k, locked, exp_lck[k]);
            end
        end
    endtask

    task automatic test_advance_wrap();
        logic [3:0] vals [6];
        logic [1:0] exp_idx [6];
        vals    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        for (int j = 0; j < 6; j++) begin
            ring = vals[j]; adv = 1'b1;
            tick();
            if (j >= 1) begin
                checks++;
                if (idx !== exp_idx[j-1] || idx_valid !== 1'b1 || err !== 1'b0 || locked !== 1'b1) begin
                    errors++;
                    $display("FAIL advance[%0d]: idx=%0d vld=%b err=%b lck=%b, required idx=%0d 1 0 1",
                             j, idx, idx_valid, err, locked, exp_idx[j-1]);
                end
            end
        end
        ring = 4'b0100; adv = 1'b0;
        tick();
        checks++;
        if (idx !== 2'd1 || err !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL advance_tail: idx=%0d err=%b lck=%b, required 1 0 1", idx, err, locked);
        end
        tick(); tick();
        checks++;
        if (idx !== 2'd2 || err !== 1'b0 || locked !== 1'b1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL advance_settle: idx=%0d err=%b lck=%b cnt=%0d, required 2 0 1 0",
                     idx, err, locked, err_cnt);
        end
    endtask

    task automatic test_bad_onehot();
        ring = 4'b0011; adv = 1'b0;
        tick();
        ring = 4'b0100;
        tick();
        checks++;
        if (idx_valid !== 1'b0 || idx !== 2'd2 || err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bad_onehot: vld=%b idx=%0d err=%b cnt=%0d lck=%b, required 0 2 1 1 0",
                     idx_valid, idx, err, err_cnt, locked);
        end
        tick();
        checks++;
        if (err !== 1'b0 || locked !== 1'b0 || idx_valid !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bad_onehot_pulse: err=%b lck=%b vld=%b cnt=%0d, required 0 0 1 1",
                     err, locked, idx_valid, err_cnt);
        end
        tick();
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: locked=%b, required 0", locked);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL relock: locked=%b err=%b, required 1 0", locked, err);
        end
    endtask

    task automatic test_adv_no_move();
        ring = 4'b0100; adv = 1'b1;
        tick();
        adv = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL stuck_pre: err=%b lck=%b, required 0 1", err, locked);
        end
        tick();
        checks++;
        if (err !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL stuck: err=%b cnt=%0d lck=%b, required 1 2 0", err, err_cnt, locked);
        end
        tick();
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL stuck_post: err=%b cnt=%0d, required 0 2", err, err_cnt);
        end
    endtask

    task automatic test_midrun_reset();
        tick(); tick();
        checks++;
        if (locked !== 1'b1 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL pre_reset: locked=%b cnt=%0d, required 1 2", locked, err_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; ring = 4'b0001;
        checks++;
        if (idx !== 2'd0 || idx_valid !== 1'b0 || locked !== 1'b0 || err_cnt !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: idx=%0d vld=%b lck=%b cnt=%0d err=%b, required 0 0 0 0 0",
                     idx, idx_valid, locked, err_cnt, err);
        end
        tick(); tick(); tick();
        checks++;
        if (locked !== 1'b0 || idx_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_hunt: locked=%b vld=%b, required 0 1", locked, idx_valid);
        end
        tick();
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_lock: locked=%b, required 1", locked);
        end
    endtask

    task automatic test_saturate();
        rst = 1'b1; ring = 4'b0001; adv = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ring = 4'b0001;
            tick(); tick(); tick(); tick();
            checks++;
            if (locked3 !== 1'b1) begin
                errors++;
                $display("FAIL sat_lock[%0d]: locked=%b, required 1", i, locked3);
            end
            ring = 4'b0011;
            tick();
            ring = 4'b0001;
            tick();
            checks++;
            if (err3 !== 1'b1 || err_cnt3 !== 3'((i + 1 > 7) ? 7 : i + 1)) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: err=%b cnt=%0d, required 1 %0d",
                         i, err3, err_cnt3, (i + 1 > 7) ? 7 : i + 1);
            end
        end
        checks++;
        if (err_cnt !== 8'd10) begin
            errors++;
            $display("FAIL wide_cnt: cnt=%0d, required 10", err_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; adv = 1'b0; ring = 4'b0001;
        test_reset();
        test_hold_lock();
        test_advance_wrap();
        test_bad_onehot();
        test_adv_no_move();
        test_midrun_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ring_chk.md
Name: ring_chk

Overview:
- Receive-side companion to the 4-bit one-hot ring counter.
- Samples the ring outputs together with the counter's advance strobe and checks that each new value is a legal one-hot word.
- Checks that each value is the correct successor of the previous one: rotated by one position if the advance strobe was high, unchanged if it was low.
- Produces the binary ring index, a lock indication, a one-cycle error pulse and a saturating error count. Sits directly downstream of the ring counter, as its in-system monitor.

Parameters:
- N, 4: ring width (number of one-hot outputs).
- IDXW, 2: index width; must equal clog2(N).
- LOCK_CNT, 2: consecutive good transitions required to enter LOCKED.
- ERRW, 8: width of the error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- adv  input  1  ring counter advance strobe; same signal that drives the counter's in.
- ring  input  N  ring counter outputs; bit i = result i; the counter resets to bit 0 set.
- idx  output  IDXW  decoded ring position.
- idx_valid  output  1  idx holds the decode of a legal one-hot sample.
- locked  output  1  checker is in LOCKED state.
- err  output  1  one-cycle pulse on a violation detected while LOCKED.
- err_cnt  output  ERRW  count of err pulses, saturating.

Behaviour:
- Reset: synchronous, active-high.
  - When rst=1 at a rising edge: idx=0, idx_valid=0, locked=0, err=0, err_cnt=0.
  - Input registers and the previous-sample register are cleared; the FSM goes to HUNT.
  - rst has priority over all other events; asserting it mid-operation aborts lock and clears err_cnt.
- Stage 1:
  - ring and adv are registered every cycle as ring_q and adv_q.
  - The previous stage-1 values are held as prev_ring and prev_adv, with prev_ok meaning prev_ring was one-hot.
- One-hot test: ring_q has exactly one bit set. The index is the position of that bit.
- Expected successor:
  - If prev_adv=1: prev_ring rotated toward the MSB by 1, so bit N-1 wraps to bit 0.
  - If prev_adv=0: prev_ring unchanged.
- A transition is good when ring_q is one-hot, prev_ok=1 and ring_q equals the expected successor.
- Outputs are registered from stage 1.
  - Latency: ring applied before edge k appears on idx after edge k+1.
  - idx_valid = one-hot result of that sample. When the sample is not one-hot, idx holds its last value and idx_valid=0.
- FSM states: HUNT, LOCKED. A good-transition counter good_cnt is 0..LOCK_CNT.
  - HUNT, good transition: good_cnt increments. When it reaches LOCK_CNT, the next state is LOCKED and locked=1 from the same edge that updates idx.
  - HUNT, bad transition or non-one-hot sample: good_cnt=0. No err pulse is raised in HUNT.
  - LOCKED, good transition: stay in LOCKED.
  - LOCKED, mismatch or non-one-hot sample: err=1 for exactly one cycle, err_cnt+1 (saturates at 2^ERRW-1), next state HUNT, good_cnt=0, locked=0 on the same edge.
- Wrap: index N-1 followed by 0 with adv=1 is a good transition.
- Simultaneous adv and hold: the expected successor always uses adv as sampled with the previous ring value, because the counter updates on the same edge at which it samples in.

Decomposition:
- ring_pkg holds:
  - localparam N default and IDXW;
  - typedef enum state_t {HUNT, LOCKED};
  - a function for the rotate-by-one successor.
- One combinational sub-module, onehot_dec (N, IDXW): input ring, outputs is_onehot and idx. The main module instantiates it on ring_q.

Test Plan:
1. Reset, then ring=0001 with adv=0 held for 5 cycles -> idx=0, idx_valid=1 two edges after release; locked=1 after 2 good transitions; err=0; err_cnt=0.
2. Locked, then adv=1 continuously with ring driven 0010,0100,1000,0001,0010 -> idx follows 1,2,3,0,1 at 2-cycle latency; the 3->0 wrap raises no err; locked stays 1.
3. Locked, then inject ring=0011 for one cycle -> idx_valid=0 that output cycle, err pulses 1 cycle, err_cnt=1, locked=0; relock after 2 further good transitions.
4. Locked, then adv=1 while ring holds 0100 -> err pulse, err_cnt increments by 1, FSM goes to HUNT.
5. ERRW=3: ten lock/violate sequences -> err_cnt stops at 7; err still pulses on every violation.
6. Locked with err_cnt=2, then rst=1 for one cycle -> next cycle idx=0, idx_valid=0, locked=0, err_cnt=0; ring=0001 then needs LOCK_CNT good transitions to relock.
